uart_frame_rx: RTL and testbench

UART_FRAME_RX -- requirements
Module: uart_frame_rx

---
 rtl/uart_frame_rx.sv | 181 ++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// uart_frame_rx
//   Parses framed packets from a byte stream coming out of a UART receiver.
//   Frame layout: SOF, LEN, LEN payload bytes, CSUM. The bytes LEN + payload + CSUM
//   must sum to zero mod 256. Payload bytes are forwarded on a registered
//   AXI-Stream style output, and the final payload byte carries tlast.
//
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   s_axis_tdata   received byte (8)
//   s_axis_tvalid  received byte valid
//   s_axis_tready  block accepts the received byte
//   m_axis_tdata   payload byte (8)
//   m_axis_tvalid  payload byte valid
//   m_axis_tready  downstream accepts the payload byte
//   m_axis_tlast   final payload byte of the frame
//   frame_ok       one-cycle pulse: checksum correct
//   frame_err      one-cycle pulse: frame rejected or aborted
//   err_code       reason with frame_err (01 length, 10 checksum, 11 timeout), sticky
module uart_frame_rx #(
  parameter logic [7:0]  SOF         = 8'h7E,
  parameter int unsigned MAX_LEN     = 32,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int unsigned   CNT_W     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic [7:0]       csum_q;
  logic [7:0]       rem_q;
  logic [7:0]       m_tdata_q;
  logic             m_tvalid_q;
  logic             m_tlast_q;
  logic             frame_ok_q;
  logic             frame_err_q;
  logic [1:0]       err_code_q;

  logic             in_hs;
  logic             len_bad;
  logic             tmo_hit;
  logic [7:0]       csum_sum;

  assign in_hs    = s_axis_tvalid & s_axis_tready;
  assign len_bad  = (s_axis_tdata == 8'd0) || (s_axis_tdata > MAX_LEN_B);
  assign csum_sum = csum_q + s_axis_tdata;
  // Only idle input cycles count toward the timeout, so a byte offered in the
  // same cycle always wins over the abort.
  assign tmo_hit  = (state_q != S_IDLE) && !s_axis_tvalid && (tmo_cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (tmo_hit) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (in_hs && s_axis_tdata == SOF) state_d = S_LEN;
        S_LEN:     if (in_hs) state_d = len_bad ? S_IDLE : S_PAYLOAD;
        S_PAYLOAD: if (in_hs && rem_q == 8'd1) state_d = S_CSUM;
        S_CSUM:    if (in_hs) state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Output logic: input back-pressure only while the output register is
  // occupied and the downstream is stalled.
  always_comb begin
    s_axis_tready = 1'b0;
    if (!rst) begin
      case (state_q)
        S_PAYLOAD: s_axis_tready = !m_tvalid_q || m_axis_tready;
        default:   s_axis_tready = 1'b1;
      endcase
    end
  end

  // Datapath: timeout counter, checksum, remaining count, output register, pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q   <= '0;
      csum_q      <= 8'd0;
      rem_q       <= 8'd0;
      m_tdata_q   <= 8'd0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;

      if (state_q == S_IDLE || s_axis_tvalid || tmo_hit) begin
        tmo_cnt_q <= '0;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end

      // A pending byte drains regardless of state, including after a timeout.
      if (m_axis_tready) begin
        m_tvalid_q <= 1'b0;
        m_tlast_q  <= 1'b0;
      end

      case (state_q)
        S_LEN: begin
          if (in_hs) begin
            if (len_bad) begin
              frame_err_q <= 1'b1;
              err_code_q  <= 2'b01;
            end else begin
              csum_q <= s_axis_tdata;
              rem_q  <= s_axis_tdata;
            end
          end
        end
        S_PAYLOAD: begin
          if (in_hs) begin
            m_tdata_q  <= s_axis_tdata;
            m_tvalid_q <= 1'b1;
            m_tlast_q  <= (rem_q == 8'd1);
            csum_q     <= csum_sum;
            rem_q      <= rem_q - 8'd1;
          end
        end
        S_CSUM: begin
          if (in_hs) begin
            if (csum_sum == 8'd0) begin
              frame_ok_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
              err_code_q  <= 2'b10;
            end
          end
        end
        default: ;
      endcase

      if (tmo_hit) begin
        frame_err_q <= 1'b1;
        err_code_q  <= 2'b11;
      end
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign frame_ok      = frame_ok_q;
  assign frame_err     = frame_err_q;
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed testbench for uart_frame_rx. A negedge monitor collects output
// bytes and status pulses; each test task drives a scenario and checks the
// collected results against hand-computed expectations.
module tb_uart_frame_rx;

  localparam int T = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready = 1'b1;
  logic       m_tlast;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  int asserts = 0;
  int fails   = 0;

  uart_frame_rx #(
    .SOF(8'h7E),
    .MAX_LEN(32),
    .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axis_tdata(s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast),
    .frame_ok(frame_ok),
    .frame_err(frame_err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  logic [7:0] q_data[$];
  bit         q_last[$];
  int         q_cyc[$];
  int         ok_cnt, err_cnt, both_cnt, stall_viol, rdy_viol;
  logic [1:0] last_code;
  logic       prev_v, prev_r, prev_l;
  logic [7:0] prev_d;

  initial begin
    ok_cnt = 0; err_cnt = 0; both_cnt = 0; stall_viol = 0; rdy_viol = 0;
    last_code = 2'bxx; prev_v = 0; prev_r = 0; prev_l = 0; prev_d = 0;
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_v = 0;
    end else begin
      if (m_tvalid && m_tready) begin
        q_data.push_back(m_tdata);
        q_last.push_back(m_tlast);
        q_cyc.push_back(cyc);
      end
      if (frame_ok) ok_cnt++;
      if (frame_err) begin
        err_cnt++;
        last_code = err_code;
      end
      if (frame_ok && frame_err) both_cnt++;
      if (prev_v && !prev_r && !(m_tvalid && m_tdata == prev_d && m_tlast == prev_l))
        stall_viol++;
      if (!s_tready && !(m_tvalid && !m_tready)) rdy_viol++;
      prev_v = m_tvalid; prev_r = m_tready; prev_d = m_tdata; prev_l = m_tlast;
    end
  end

  task automatic clear_mon();
    q_data.delete(); q_last.delete(); q_cyc.delete();
    ok_cnt = 0; err_cnt = 0; both_cnt = 0; stall_viol = 0; rdy_viol = 0;
    last_code = 2'bxx;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    s_tdata  = b;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) begin
      asserts++; fails++;
      $display("FAIL send_timeout byte=%02h: s_axis_tready stayed 0, required 1", b);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    @(negedge clk);
    asserts++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid got=%b exp=0", m_tvalid); end
    asserts++; if (m_tlast !== 1'b0) begin fails++; $display("FAIL rst_tlast got=%b exp=0", m_tlast); end
    asserts++; if (m_tdata !== 8'h00) begin fails++; $display("FAIL rst_tdata got=%02h exp=00", m_tdata); end
    asserts++; if (frame_ok !== 1'b0) begin fails++; $display("FAIL rst_ok got=%b exp=0", frame_ok); end
    asserts++; if (frame_err !== 1'b0) begin fails++; $display("FAIL rst_err got=%b exp=0", frame_err); end
    asserts++; if (err_code !== 2'b00) begin fails++; $display("FAIL rst_code got=%b exp=00", err_code); end
    asserts++; if (s_tready !== 1'b0) begin fails++; $display("FAIL rst_sready got=%b exp=0", s_tready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    asserts++; if (s_tready !== 1'b1) begin fails++; $display("FAIL post_rst_sready got=%b exp=1", s_tready); end
    $display("test_reset done");
  endtask

  task automatic test_good_frame();
    logic [7:0] exp_d[3];
    exp_d = '{8'h11, 8'h22, 8'h33};
    @(posedge clk); #1;
    clear_mon();
    m_tready = 1'b1;
    send_byte(8'h7E); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h97);
    idle(4);
    asserts++; if (q_data.size() !== 3) begin fails++; $display("FAIL good_count got=%0d exp=3", q_data.size()); end
    for (int i = 0; i < 3 && i < q_data.size(); i++) begin
      asserts++; if (q_data[i] !== exp_d[i]) begin fails++; $display("FAIL good_data[%0d] got=%02h exp=%02h", i, q_data[i], exp_d[i]); end
      asserts++; if (q_last[i] !== (i == 2)) begin fails++; $display("FAIL good_last[%0d] got=%b exp=%b", i, q_last[i], (i == 2)); end
    end
    if (q_cyc.size() == 3) begin
      asserts++; if (q_cyc[2] - q_cyc[0] !== 2) begin fails++; $display("FAIL good_rate span=%0d exp=2", q_cyc[2] - q_cyc[0]); end
    end
    asserts++; if (ok_cnt !== 1) begin fails++; $display("FAIL good_ok got=%0d exp=1", ok_cnt); end
    asserts++; if (err_cnt !== 0) begin fails++; $display("FAIL good_err got=%0d exp=0", err_cnt); end
    $display("test_good_frame: %0d bytes ok=%0d err=%0d", q_data.size(), ok_cnt, err_cnt);
  endtask

  task automatic test_bad_csum();
    clear_mon();
    send_byte(8'h7E); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h98);
    idle(4);
    asserts++; if (q_data.size() !== 3) begin fails++; $display("FAIL csum_count got=%0d exp=3", q_data.size()); end
    if (q_data.size() == 3) begin
      asserts++; if (q_data[2] !== 8'h33 || q_last[2] !== 1'b1) begin fails++; $display("FAIL csum_last got=%02h/%b exp=33/1", q_data[2], q_last[2]); end
    end
    asserts++; if (err_cnt !== 1) begin fails++; $display("FAIL csum_err got=%0d exp=1", err_cnt); end
    asserts++; if (last_code !== 2'b10) begin fails++; $display("FAIL csum_code got=%b exp=10", last_code); end
    asserts++; if (ok_cnt !== 0) begin fails++; $display("FAIL csum_ok got=%0d exp=0", ok_cnt); end
    $display("test_bad_csum: err=%0d code=%b", err_cnt, last_code);
  endtask

  task automatic test_bad_len();
    clear_mon();
    send_byte(8'h00); send_byte(8'h55); send_byte(8'h7E); send_byte(8'h00);
    idle(3);
    asserts++; if (q_data.size() !== 0) begin fails++; $display("FAIL len0_count got=%0d exp=0", q_data.size()); end
    asserts++; if (err_cnt !== 1) begin fails++; $display("FAIL len0_err got=%0d exp=1", err_cnt); end
    asserts++; if (last_code !== 2'b01) begin fails++; $display("FAIL len0_code got=%b exp=01", last_code); end
    clear_mon();
    send_byte(8'h7E); send_byte(8'h21);
    idle(3);
    asserts++; if (err_cnt !== 1) begin fails++; $display("FAIL len33_err got=%0d exp=1", err_cnt); end
    asserts++; if (last_code !== 2'b01) begin fails++; $display("FAIL len33_code got=%b exp=01", last_code); end
    asserts++; if (q_data.size() !== 0) begin fails++; $display("FAIL len33_count got=%0d exp=0", q_data.size()); end
    $display("test_bad_len: err=%0d code=%b", err_cnt, last_code);
  endtask

  task automatic test_max_len();
    int nl;
    clear_mon();
    send_byte(8'h7E); send_byte(8'h20);
    for (int i = 0; i < 32; i++) send_byte(8'h01);
    send_byte(8'hC0);
    idle(4);
    nl = 0;
    foreach (q_last[i]) if (q_last[i]) nl++;
    asserts++; if (q_data.size() !== 32) begin fails++; $display("FAIL max_count got=%0d exp=32", q_data.size()); end
    asserts++; if (nl !== 1 || q_last.size() != 32 || q_last[31] !== 1'b1) begin fails++; $display("FAIL max_last count=%0d exp=1 on final", nl); end
    asserts++; if (ok_cnt !== 1 || err_cnt !== 0) begin fails++; $display("FAIL max_status ok=%0d err=%0d exp=1/0", ok_cnt, err_cnt); end
    $display("test_max_len: %0d bytes ok=%0d", q_data.size(), ok_cnt);
  endtask

  task automatic test_timeout();
    int n;
    clear_mon();
    m_tready = 1'b0;
    send_byte(8'h7E); send_byte(8'h02); send_byte(8'hAA);
    idle(T - 1);
    asserts++; if (err_cnt !== 0) begin fails++; $display("FAIL tmo_early err=%0d exp=0", err_cnt); end
    n = 0;
    while (err_cnt == 0 && n < 3 * T) begin idle(1); n++; end
    idle(1);
    asserts++; if (err_cnt !== 1) begin fails++; $display("FAIL tmo_err got=%0d exp=1", err_cnt); end
    asserts++; if (last_code !== 2'b11) begin fails++; $display("FAIL tmo_code got=%b exp=11", last_code); end
    asserts++; if (q_data.size() !== 0) begin fails++; $display("FAIL tmo_stalled_count got=%0d exp=0", q_data.size()); end
    m_tready = 1'b1;
    idle(3);
    asserts++; if (q_data.size() !== 1) begin fails++; $display("FAIL tmo_drain_count got=%0d exp=1", q_data.size()); end
    if (q_data.size() == 1) begin
      asserts++; if (q_data[0] !== 8'hAA || q_last[0] !== 1'b0) begin fails++; $display("FAIL tmo_drain got=%02h/%b exp=AA/0", q_data[0], q_last[0]); end
    end
    clear_mon();
    send_byte(8'h7E); send_byte(8'h01); send_byte(8'h5A); send_byte(8'hA5);
    idle(4);
    asserts++; if (q_data.size() !== 1 || q_data[0] !== 8'h5A || q_last[0] !== 1'b1) begin fails++; $display("FAIL tmo_next count=%0d exp one 5A with tlast", q_data.size()); end
    asserts++; if (ok_cnt !== 1 || err_cnt !== 0) begin fails++; $display("FAIL tmo_next_status ok=%0d err=%0d exp=1/0", ok_cnt, err_cnt); end
    $display("test_timeout: code=%b next ok=%0d", last_code, ok_cnt);
  endtask

  task automatic test_stall();
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    clear_mon();
    fork
      begin
        send_byte(8'h7E); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h97);
      end
      begin
        for (int i = 0; i < 16; i++) begin
          m_tready = pat[i % 4];
          @(posedge clk); #1;
        end
      end
    join
    m_tready = 1'b1;
    idle(4);
    asserts++; if (q_data.size() !== 3) begin fails++; $display("FAIL stall_count got=%0d exp=3", q_data.size()); end
    if (q_data.size() == 3) begin
      asserts++; if (q_data[0] !== 8'h11 || q_data[1] !== 8'h22 || q_data[2] !== 8'h33)
        begin fails++; $display("FAIL stall_data got=%02h %02h %02h exp=11 22 33", q_data[0], q_data[1], q_data[2]); end
      asserts++; if (q_last[0] !== 1'b0 || q_last[1] !== 1'b0 || q_last[2] !== 1'b1)
        begin fails++; $display("FAIL stall_last got=%b%b%b exp=001", q_last[0], q_last[1], q_last[2]); end
    end
    asserts++; if (stall_viol !== 0) begin fails++; $display("FAIL stall_hold violations=%0d exp=0", stall_viol); end
    asserts++; if (rdy_viol !== 0) begin fails++; $display("FAIL stall_sready violations=%0d exp=0", rdy_viol); end
    asserts++; if (ok_cnt !== 1 || err_cnt !== 0) begin fails++; $display("FAIL stall_status ok=%0d err=%0d exp=1/0", ok_cnt, err_cnt); end
    $display("test_stall: %0d bytes ok=%0d", q_data.size(), ok_cnt);
  endtask

  task automatic test_reset_mid();
    m_tready = 1'b0;
    send_byte(8'h7E); send_byte(8'h03); send_byte(8'h11);
    clear_mon();
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    asserts++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL rstmid_tvalid got=%b exp=0", m_tvalid); end
    @(posedge clk); #1;
    rst = 1'b0;
    m_tready = 1'b1;
    idle(3);
    asserts++; if (ok_cnt !== 0 || err_cnt !== 0 || q_data.size() !== 0)
      begin fails++; $display("FAIL rstmid_quiet ok=%0d err=%0d bytes=%0d exp=0/0/0", ok_cnt, err_cnt, q_data.size()); end
    send_byte(8'h7E); send_byte(8'h01); send_byte(8'h5A); send_byte(8'hA5);
    idle(4);
    asserts++; if (q_data.size() !== 1 || q_data[0] !== 8'h5A || q_last[0] !== 1'b1)
      begin fails++; $display("FAIL rstmid_next count=%0d exp one 5A with tlast", q_data.size()); end
    asserts++; if (ok_cnt !== 1 || err_cnt !== 0) begin fails++; $display("FAIL rstmid_status ok=%0d err=%0d exp=1/0", ok_cnt, err_cnt); end
    $display("test_reset_mid: bytes=%0d ok=%0d", q_data.size(), ok_cnt);
  endtask

  task automatic test_back_to_back();
    clear_mon();
    m_tready = 1'b1;
    send_byte(8'h7E); send_byte(8'h01); send_byte(8'h5A); send_byte(8'hA5);
    send_byte(8'h7E); send_byte(8'h02); send_byte(8'h01); send_byte(8'h02); send_byte(8'hFB);
    idle(4);
    asserts++; if (q_data.size() !== 3) begin fails++; $display("FAIL b2b_count got=%0d exp=3", q_data.size()); end
    if (q_data.size() == 3) begin
      asserts++; if (q_data[0] !== 8'h5A || q_data[1] !== 8'h01 || q_data[2] !== 8'h02)
        begin fails++; $display("FAIL b2b_data got=%02h %02h %02h exp=5A 01 02", q_data[0], q_data[1], q_data[2]); end
      asserts++; if (q_last[0] !== 1'b1 || q_last[1] !== 1'b0 || q_last[2] !== 1'b1)
        begin fails++; $display("FAIL b2b_last got=%b%b%b exp=101", q_last[0], q_last[1], q_last[2]); end
    end
    asserts++; if (ok_cnt !== 2 || err_cnt !== 0) begin fails++; $display("FAIL b2b_status ok=%0d err=%0d exp=2/0", ok_cnt, err_cnt); end
    $display("test_back_to_back: bytes=%0d ok=%0d", q_data.size(), ok_cnt);
  endtask

  int total_both = 0;

  initial begin
    test_reset();
    test_good_frame();
    total_both += both_cnt;
    test_bad_csum();
    total_both += both_cnt;
    test_bad_len();
    total_both += both_cnt;
    test_max_len();
    total_both += both_cnt;
    test_timeout();
    total_both += both_cnt;
    test_stall();
    total_both += both_cnt;
    test_reset_mid();
    total_both += both_cnt;
    test_back_to_back();
    total_both += both_cnt;
    asserts++;
    if (total_both !== 0) begin
      fails++;
      $display("FAIL ok_err_overlap cycles=%0d exp=0", total_both);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
